// File: rtl/cpu_defs_pkg.sv
// cpu_defs_pkg: definitions shared by the multicycle control unit and the datapath.
//   state_t   - control FSM states (5-bit, also exported on the debug 'state' port)
//   iclass_t  - decoded instruction class produced by mc_decode
//   OP_*/FN_* - opcode and R-type funct field values
//   ALU_*, SH_*, SRCB_*, M2R_*, PCS_* - datapath command / mux-select encodings
package cpu_defs_pkg;

  typedef enum logic [4:0] {
    S_RESET  = 5'd0,
    S_FETCH  = 5'd1,
    S_FWAIT  = 5'd2,
    S_DECODE = 5'd3,
    S_RALU   = 5'd4,
    S_RWB    = 5'd5,
    S_SHLD   = 5'd6,
    S_SHOP   = 5'd7,
    S_SHWB   = 5'd8,
    S_JR     = 5'd9,
    S_ADDI   = 5'd10,
    S_IWB    = 5'd11,
    S_ADDR   = 5'd12,
    S_MEMRD  = 5'd13,
    S_MDR    = 5'd14,
    S_LWB    = 5'd15,
    S_SW     = 5'd16,
    S_BRANCH = 5'd17,
    S_J      = 5'd18,
    S_EXC0   = 5'd19,
    S_EXC1   = 5'd20
  } state_t;

  typedef enum logic [3:0] {
    C_ADD, C_SUB, C_AND, C_SLL, C_SRL, C_JR,
    C_ADDI, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_INV
  } iclass_t;

  // opcode field IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // funct field IR[5:0], R-type only
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  localparam logic [2:0] ALU_PASSA = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_CMP   = 3'b111;

  localparam logic [2:0] SH_HOLD = 3'b000;
  localparam logic [2:0] SH_LOAD = 3'b001;
  localparam logic [2:0] SH_SLL  = 3'b010;
  localparam logic [2:0] SH_SRL  = 3'b011;

  localparam logic [3:0] SRCB_B       = 4'd0;
  localparam logic [3:0] SRCB_FOUR    = 4'd1;
  localparam logic [3:0] SRCB_SEXT    = 4'd2;
  localparam logic [3:0] SRCB_SEXT_SH = 4'd3;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_SHIFT  = 2'd2;

  localparam logic [3:0] PCS_ALURES = 4'd0;
  localparam logic [3:0] PCS_ALUOUT = 4'd1;
  localparam logic [3:0] PCS_JUMP   = 4'd2;
  localparam logic [3:0] PCS_EPC    = 4'd3;
  localparam logic [3:0] PCS_EXCVEC = 4'd4;

  // Classes whose ALU result traps on signed overflow ('and' never does).
  function automatic logic ovf_traps(input iclass_t c);
    return (c == C_ADD) || (c == C_SUB) || (c == C_ADDI);
  endfunction

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational instruction classifier.
//   opcode  in  6  IR[31:26]
//   funct   in  6  IR[5:0]
//   iclass  out    instruction class (C_INV for anything unsupported)
//   invalid out 1  opcode/funct combination not supported
import cpu_defs_pkg::*;

module mc_decode (
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    iclass,
  output logic       invalid
);

  always_comb begin
    iclass = C_INV;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  iclass = C_ADD;
          FN_SUB:  iclass = C_SUB;
          FN_AND:  iclass = C_AND;
          FN_SLL:  iclass = C_SLL;
          FN_SRL:  iclass = C_SRL;
          FN_JR:   iclass = C_JR;
          default: iclass = C_INV;
        endcase
      end
      OP_ADDI: iclass = C_ADDI;
      OP_LW:   iclass = C_LW;
      OP_SW:   iclass = C_SW;
      OP_BEQ:  iclass = C_BEQ;
      OP_BNE:  iclass = C_BNE;
      OP_J:    iclass = C_J;
      default: iclass = C_INV;
    endcase
    invalid = (iclass == C_INV);
  end

endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle Moore control FSM for the MIPS-subset CPU.
//   clk, reset (sync, active low)
//   OPCODE/FUNCT      instruction fields from IR
//   Overflow, Igual   ALU status (same cycle)
//   PCwrite, MemWrite, MemRead, IRWrite, RegWrite, EPCWrite  write enables
//   IorD, AluSrcA, AluSrcB, ALUControl, ShiftControl, RegDest, MemToReg,
//   PCSource          datapath selects / commands
//   state             current FSM state, debug only
// Parameter EXC_VEC_SEL is the PCSource code of the exception handler address.
import cpu_defs_pkg::*;

module mc_control_unit #(
  parameter logic [3:0] EXC_VEC_SEL = PCS_EXCVEC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OPCODE,
  input  logic [5:0] FUNCT,
  input  logic       Overflow,
  input  logic       Igual,
  output logic       PCwrite,
  output logic       MemWrite,
  output logic       MemRead,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       EPCWrite,
  output logic       IorD,
  output logic       AluSrcA,
  output logic [3:0] AluSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ShiftControl,
  output logic       RegDest,
  output logic [1:0] MemToReg,
  output logic [3:0] PCSource,
  output logic [4:0] state
);

  state_t  cur, nxt;
  iclass_t iclass;
  logic    invalid;

  // IR only changes in FWAIT, so the class stays stable for every state
  // that consults it (DECODE onwards).
  mc_decode u_dec (
    .opcode  (OPCODE),
    .funct   (FUNCT),
    .iclass  (iclass),
    .invalid (invalid)
  );

  always_ff @(posedge clk) begin
    if (!reset) cur <= S_RESET;
    else        cur <= nxt;
  end

  assign state = cur;

  always_comb begin
    nxt          = cur;
    PCwrite      = 1'b0;
    MemWrite     = 1'b0;
    MemRead      = 1'b0;
    IRWrite      = 1'b0;
    RegWrite     = 1'b0;
    EPCWrite     = 1'b0;
    IorD         = 1'b0;
    AluSrcA      = 1'b0;
    AluSrcB      = SRCB_B;
    ALUControl   = ALU_PASSA;
    ShiftControl = SH_HOLD;
    RegDest      = 1'b0;
    MemToReg     = M2R_ALUOUT;
    PCSource     = PCS_ALURES;

    case (cur)
      S_RESET: nxt = S_FETCH;

      S_FETCH: begin
        IorD = 1'b0;
        nxt  = S_FWAIT;
      end

      // instruction word arrives this cycle; PC+4 in parallel
      S_FWAIT: begin
        IRWrite    = 1'b1;
        AluSrcA    = 1'b0;
        AluSrcB    = SRCB_FOUR;
        ALUControl = ALU_ADD;
        PCSource   = PCS_ALURES;
        PCwrite    = 1'b1;
        nxt        = S_DECODE;
      end

      // speculative branch target into ALUout
      S_DECODE: begin
        AluSrcA    = 1'b0;
        AluSrcB    = SRCB_SEXT_SH;
        ALUControl = ALU_ADD;
        if (invalid) nxt = S_EXC0;
        else begin
          case (iclass)
            C_ADD, C_SUB, C_AND: nxt = S_RALU;
            C_SLL, C_SRL:        nxt = S_SHLD;
            C_JR:                nxt = S_JR;
            C_ADDI:              nxt = S_ADDI;
            C_LW, C_SW:          nxt = S_ADDR;
            C_BEQ, C_BNE:        nxt = S_BRANCH;
            C_J:                 nxt = S_J;
            default:             nxt = S_EXC0;
          endcase
        end
      end

      S_RALU: begin
        AluSrcA = 1'b1;
        AluSrcB = SRCB_B;
        case (iclass)
          C_SUB:   ALUControl = ALU_SUB;
          C_AND:   ALUControl = ALU_AND;
          default: ALUControl = ALU_ADD;
        endcase
        nxt = (ovf_traps(iclass) && Overflow) ? S_EXC0 : S_RWB;
      end

      S_RWB: begin
        RegDest  = 1'b1;
        MemToReg = M2R_ALUOUT;
        RegWrite = 1'b1;
        nxt      = S_FETCH;
      end

      S_SHLD: begin
        ShiftControl = SH_LOAD;
        nxt          = S_SHOP;
      end

      S_SHOP: begin
        ShiftControl = (iclass == C_SRL) ? SH_SRL : SH_SLL;
        nxt          = S_SHWB;
      end

      S_SHWB: begin
        MemToReg = M2R_SHIFT;
        RegDest  = 1'b1;
        RegWrite = 1'b1;
        nxt      = S_FETCH;
      end

      // A passes straight through the ALU onto PCSource 0
      S_JR: begin
        AluSrcA    = 1'b1;
        ALUControl = ALU_PASSA;
        PCSource   = PCS_ALURES;
        PCwrite    = 1'b1;
        nxt        = S_FETCH;
      end

      S_ADDI: begin
        AluSrcA    = 1'b1;
        AluSrcB    = SRCB_SEXT;
        ALUControl = ALU_ADD;
        nxt        = Overflow ? S_EXC0 : S_IWB;
      end

      S_IWB: begin
        RegDest  = 1'b0;
        MemToReg = M2R_ALUOUT;
        RegWrite = 1'b1;
        nxt      = S_FETCH;
      end

      S_ADDR: begin
        AluSrcA    = 1'b1;
        AluSrcB    = SRCB_SEXT;
        ALUControl = ALU_ADD;
        nxt        = (iclass == C_SW) ? S_SW : S_MEMRD;
      end

      S_MEMRD: begin
        IorD = 1'b1;
        nxt  = S_MDR;
      end

      // one-cycle memory latency: data addressed in MEMRD is captured here
      S_MDR: begin
        MemRead = 1'b1;
        nxt     = S_LWB;
      end

      S_LWB: begin
        MemToReg = M2R_MDR;
        RegDest  = 1'b0;
        RegWrite = 1'b1;
        nxt      = S_FETCH;
      end

      S_SW: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        nxt      = S_FETCH;
      end

      // target was computed in DECODE; the only Mealy output is PCwrite
      S_BRANCH: begin
        AluSrcA    = 1'b1;
        AluSrcB    = SRCB_B;
        ALUControl = ALU_CMP;
        PCSource   = PCS_ALUOUT;
        PCwrite    = (iclass == C_BEQ) ? Igual : !Igual;
        nxt        = S_FETCH;
      end

      S_J: begin
        PCSource = PCS_JUMP;
        PCwrite  = 1'b1;
        nxt      = S_FETCH;
      end

      // PC already points past the faulting instruction; back it up by 4
      S_EXC0: begin
        AluSrcA    = 1'b0;
        AluSrcB    = SRCB_FOUR;
        ALUControl = ALU_SUB;
        nxt        = S_EXC1;
      end

      S_EXC1: begin
        EPCWrite = 1'b1;
        PCSource = EXC_VEC_SEL;
        PCwrite  = 1'b1;
        nxt      = S_FETCH;
      end

      default: nxt = S_RESET;
    endcase

    // reset must squash any store or write-back in the very cycle it is seen
    if (!reset) begin
      PCwrite  = 1'b0;
      MemWrite = 1'b0;
      MemRead  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      EPCWrite = 1'b0;
    end
  end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multicycle control FSM for the MIPS-subset CPU. Sits directly upstream of the datapath: it takes the opcode/funct fields from the instruction register and the ALU status flags, and drives every mux select, write enable and ALU/shifter command the datapath consumes. It sequences fetch, decode, execute, memory and write-back for each instruction, and diverts to an exception sequence on an invalid opcode or arithmetic overflow.

## Interface
- EXC_VEC_SEL, 4, PCSource code that selects the exception-handler address.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- OPCODE  in  6  IR[31:26].
- FUNCT  in  6  IR[5:0].
- Overflow  in  1  ALU overflow, same-cycle combinational.
- Igual  in  1  ALU equality flag, valid when ALUControl=111.
- PCwrite, MemWrite, MemRead (MDR load), IRWrite, RegWrite, EPCWrite  out  1 each  write enables.
- IorD  out  1  0=PC, 1=ALUout.
- AluSrcA  out  1  0=PC, 1=A.
- AluSrcB  out  4  0=B, 1=const 4, 2=SignExt, 3=SignExt<<2.
- ALUControl  out  3  000 pass A, 001 add, 010 sub, 011 and, 111 compare.
- ShiftControl  out  3  000 hold, 001 load B, 010 sll, 011 srl.
- RegDest  out  1  0=rt, 1=rd.
- MemToReg  out  2  0=ALUout, 1=MDR, 2=Shiftout.
- PCSource  out  4  0=ALUResult, 1=ALUout, 2=jump address, 3=EPC, EXC_VEC_SEL=handler.
- state  out  5  current state, debug only.

## Operation
- Moore FSM. Outputs are decoded from the state only, except in BRANCH, where PCwrite also depends on Igual. Any output not listed for a state is 0.
- Supported instructions:
  - R-type (00): add 20, sub 22, and 24, sll 00, srl 02, jr 08.
  - addi 08, lw 23, sw 2B, beq 04, bne 05, j 02.
  - Any other OPCODE, or any other FUNCT under R-type, is invalid.
- States and transitions:
  - RESET: all outputs 0 → FETCH.
  - FETCH: IorD=0 → FWAIT.
  - FWAIT: IRWrite=1; PC+4 (AluSrcA=0, AluSrcB=1, ALUControl=001, PCSource=0, PCwrite=1) → DECODE.
  - DECODE: branch target ALUout = PC + SignExt<<2 (AluSrcA=0, AluSrcB=3, ALUControl=001). Next state follows the decoded class; invalid → EXC0.
  - RALU: A op B (AluSrcA=1, AluSrcB=0). Overflow on add/sub → EXC0, else RWB. Overflow is ignored for and.
  - RWB: RegDest=1, MemToReg=0, RegWrite=1 → FETCH.
  - SHLD: ShiftControl=001 → SHOP.
  - SHOP: ShiftControl=010 (sll) or 011 (srl) → SHWB.
  - SHWB: MemToReg=2, RegDest=1, RegWrite=1 → FETCH.
  - JR: AluSrcA=1, ALUControl=000, PCSource=0, PCwrite=1 → FETCH.
  - ADDI: A + SignExt (AluSrcA=1, AluSrcB=2, ALUControl=001). Overflow → EXC0, else IWB.
  - IWB: RegDest=0, MemToReg=0, RegWrite=1 → FETCH.
  - ADDR: A + SignExt → MEMRD (lw) or SW.
  - MEMRD: IorD=1 → MDR.
  - MDR: MemRead=1 → LWB.
  - LWB: MemToReg=1, RegDest=0, RegWrite=1 → FETCH.
  - SW: IorD=1, MemWrite=1 (store data = B) → FETCH.
  - BRANCH: AluSrcA=1, AluSrcB=0, ALUControl=111, PCSource=1. PCwrite = beq ? Igual : !Igual → FETCH.
  - J: PCSource=2, PCwrite=1 → FETCH.
  - EXC0: PC−4 (AluSrcA=0, AluSrcB=1, ALUControl=010) → EXC1.
  - EXC1: EPCWrite=1, PCSource=EXC_VEC_SEL, PCwrite=1 → FETCH.
- The faulting instruction never asserts RegWrite or MemWrite.

## Timing
- Memory read latency is 1 cycle. The address presented in cycle N is valid on Memout in cycle N+1.
- Cycles per instruction, counted from FETCH: branch, j, jr 4; R-ALU, addi, sw 5; shift 6; lw 7. An exception adds 2 cycles after the detecting state.
- Reset:
  - reset=0 at a rising edge → state=RESET on the next cycle, regardless of the current state.
  - While reset=0, all write enables are forced to 0 combinationally, so an in-flight MemWrite or RegWrite is suppressed in that same cycle.
  - The first FETCH occurs 1 cycle after reset returns to 1.
- Reset in the middle of an instruction abandons it; no partial write-back occurs afterwards.

## Structure
- Shared package cpu_defs_pkg holds:
  - the state enum;
  - opcode and funct constants;
  - ALUControl, ShiftControl, AluSrcB, MemToReg and PCSource encodings.
- The datapath top imports the same package.
- One sub-module, mc_decode: a combinational map from OPCODE/FUNCT to an instruction-class enum plus an invalid flag. The FSM consumes only the class.

## Test plan
- Reset held 3 cycles mid-lw (in MEMRD) → state RESET, no RegWrite ever asserted, FETCH on the 2nd cycle after release.
- add with Overflow=0 → state trace FETCH, FWAIT, DECODE, RALU, RWB; RegWrite=1 exactly 1 cycle with RegDest=1.
- add with Overflow=1 in RALU → EXC0, EXC1; EPCWrite=1 and PCSource=4 in EXC1; RegWrite never 1.
- beq with Igual=1 → PCwrite=1, PCSource=1 in BRANCH. Same with Igual=0 → PCwrite=0. bne → the inverse.
- sll → ShiftControl 001 then 010, then SHWB with MemToReg=2; 6 cycles total.
- OPCODE=3F → EXC0 directly after DECODE; sw → MemWrite=1 for exactly 1 cycle with IorD=1.
